// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the UART transmit front-end scheduler.
package uart_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    DISABLE = 2'd2,
    APPLY   = 2'd3
  } sched_state_t;

  // LCR_H bit positions
  localparam int LCR_STICK   = 7;
  localparam int LCR_WLEN_HI = 6;
  localparam int LCR_WLEN_LO = 5;
  localparam int LCR_RSVD    = 4;
  localparam int LCR_STP2    = 3;
  localparam int LCR_EPS     = 2;
  localparam int LCR_PEN     = 1;
  localparam int LCR_BRK     = 0;

  // 8 data bits, no parity, 1 stop, no break
  localparam logic [7:0] LCR_RST_VAL = 8'h60;

  // Cycles the transmitter sees tx_en low during an update
  localparam int DISABLE_CYCLES = 2;

  typedef struct packed {
    logic [7:0] lcr;
    logic       tx_en;
    logic       uart_en;
  } cfg_t;

endpackage

// File: rtl/uart_tx_sched_arb.sv
// Combinational round-robin arbiter: first requester at or after pointer wins.
module uart_rr_arb #(
  parameter int NREQ = 2,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   pointer,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   winner
);

  int   idx;
  logic hit;

  // Scan requesters starting at the pointer, wrapping modulo NREQ
  always_comb begin
    grant  = '0;
    winner = '0;
    hit    = 1'b0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(pointer) + k) % NREQ;
      if (enable && !hit && req[idx]) begin
        hit        = 1'b1;
        grant[idx] = 1'b1;
        winner     = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// UART transmit front-end: round-robin byte arbitration into a one-entry hold,
// plus drain/disable/apply/re-enable sequencing of line and control settings.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int         NREQ    = 2,
  parameter logic [7:0] LCR_RST = LCR_RST_VAL
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              cfg_wr,
  input  logic [7:0]        cfg_lcr,
  input  logic              cfg_tx_en,
  input  logic              cfg_uart_en,
  output logic              cfg_ready,
  output logic              cfg_busy,
  output logic [7:0]        fifo_data,
  output logic              fifo_data_valid,
  input  logic              fifo_data_taken,
  input  logic              tx_fifo_busy,
  output logic              stick_parity_sel,
  output logic [1:0]        word_len,
  output logic              two_stop_bits,
  output logic              even_parity_sel,
  output logic              parity_en,
  output logic              send_break,
  output logic              tx_en,
  output logic              UART_en
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(DISABLE_CYCLES + 1);

  sched_state_t    state, state_nx;
  logic [CW-1:0]   dis_cnt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   winner;
  logic            arb_en;
  cfg_t            pend;
  logic [7:0]      lcr_q;
  logic            unused_lcr_bit;

  uart_rr_arb #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req     (req_valid),
    .pointer (ptr),
    .enable  (arb_en),
    .grant   (req_ready),
    .winner  (winner)
  );

  // Next state, grant enable and config handshake; config request beats a grant
  always_comb begin
    state_nx  = state;
    arb_en    = 1'b0;
    cfg_ready = 1'b0;
    case (state)
      RUN: begin
        if (cfg_wr) begin
          cfg_ready = 1'b1;
          state_nx  = DRAIN;
        end else begin
          arb_en = !fifo_data_valid || fifo_data_taken;
        end
      end
      // A byte held while the transmitter is disabled can never drain, so it is kept
      DRAIN:   if (!tx_fifo_busy && (!fifo_data_valid || !(tx_en && UART_en))) state_nx = DISABLE;
      DISABLE: if (dis_cnt == CW'(DISABLE_CYCLES - 1)) state_nx = APPLY;
      APPLY:   state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  // State register and DISABLE dwell counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= RUN;
      dis_cnt <= '0;
    end else begin
      state   <= state_nx;
      dis_cnt <= (state == DISABLE) ? dis_cnt + 1'b1 : '0;
    end
  end

  // Holding register and round-robin pointer; taken+grant reloads back-to-back
  always_ff @(posedge CLK) begin
    if (RST) begin
      fifo_data       <= 8'h00;
      fifo_data_valid <= 1'b0;
      ptr             <= '0;
    end else if (|req_ready) begin
      fifo_data       <= req_data[8*int'(winner) +: 8];
      fifo_data_valid <= 1'b1;
      ptr             <= (int'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
    end else if (fifo_data_taken) begin
      fifo_data_valid <= 1'b0;
    end
  end

  // Pending configuration captured on an accepted request
  always_ff @(posedge CLK) begin
    if (cfg_ready) pend <= '{lcr: cfg_lcr, tx_en: cfg_tx_en, uart_en: cfg_uart_en};
  end

  // tx_en drops for the DISABLE_CYCLES cycles ending with APPLY; LCR and UART_en
  // change on the edge into APPLY while tx_en is low; tx_en returns on RUN entry
  always_ff @(posedge CLK) begin
    if (RST) begin
      lcr_q   <= LCR_RST;
      tx_en   <= 1'b0;
      UART_en <= 1'b0;
    end else begin
      if (state == DISABLE) begin
        tx_en <= 1'b0;
        if (state_nx == APPLY) begin
          lcr_q   <= pend.lcr;
          UART_en <= pend.uart_en;
        end
      end
      if (state == APPLY) tx_en <= pend.tx_en;
    end
  end

  assign cfg_busy         = (state != RUN);
  assign stick_parity_sel = lcr_q[LCR_STICK];
  assign word_len         = lcr_q[LCR_WLEN_HI:LCR_WLEN_LO];
  assign two_stop_bits    = lcr_q[LCR_STP2];
  assign even_parity_sel  = lcr_q[LCR_EPS];
  assign parity_en        = lcr_q[LCR_PEN];
  assign send_break       = lcr_q[LCR_BRK];
  assign unused_lcr_bit   = lcr_q[LCR_RSVD];

endmodule

// File: tb/tb_uart_tx_sched.sv
// Testbench for uart_tx_sched: scoreboard of expected bytes, transmitter model.
module tb_uart_tx_sched;

  localparam int FRAME = 2;

  logic        CLK;
  logic        RST;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic        cfg_wr;
  logic [7:0]  cfg_lcr;
  logic        cfg_tx_en;
  logic        cfg_uart_en;
  logic        cfg_ready;
  logic        cfg_busy;
  logic [7:0]  fifo_data;
  logic        fifo_data_valid;
  logic        fifo_data_taken;
  logic        tx_fifo_busy;
  logic        stick_parity_sel;
  logic [1:0]  word_len;
  logic        two_stop_bits;
  logic        even_parity_sel;
  logic        parity_en;
  logic        send_break;
  logic        tx_en;
  logic        UART_en;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [7:0]  sb[$];
  logic        model_on = 1'b1;
  logic        man_busy = 1'b0;
  logic        man_taken = 1'b0;
  int          b2b_req = 0;
  int          ph = 0;

  uart_tx_sched #(.NREQ(2), .LCR_RST(8'h60)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .cfg_wr           (cfg_wr),
    .cfg_lcr          (cfg_lcr),
    .cfg_tx_en        (cfg_tx_en),
    .cfg_uart_en      (cfg_uart_en),
    .cfg_ready        (cfg_ready),
    .cfg_busy         (cfg_busy),
    .fifo_data        (fifo_data),
    .fifo_data_valid  (fifo_data_valid),
    .fifo_data_taken  (fifo_data_taken),
    .tx_fifo_busy     (tx_fifo_busy),
    .stick_parity_sel (stick_parity_sel),
    .word_len         (word_len),
    .two_stop_bits    (two_stop_bits),
    .even_parity_sel  (even_parity_sel),
    .parity_en        (parity_en),
    .send_break       (send_break),
    .tx_en            (tx_en),
    .UART_en          (UART_en)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (k < 80 && !(sb.size() == 0 && ph == 0 && !fifo_data_valid)) begin
      @(negedge CLK);
      k++;
    end
    chk(tag, k < 80, 1);
  endtask

  // Transmitter model: latch when enabled, pulse taken next cycle, then a short frame
  initial begin : xmtr
    int         frame;
    int         b2b_done;
    logic [7:0] exp_b;
    fifo_data_taken = 1'b0;
    tx_fifo_busy    = 1'b0;
    frame    = 0;
    b2b_done = 0;
    exp_b    = 8'h00;
    forever begin
      @(negedge CLK);
      if (!model_on) begin
        fifo_data_taken = man_taken;
        tx_fifo_busy    = man_busy;
        ph = 0;
      end else begin
        fifo_data_taken = 1'b0;
        case (ph)
          0: if (fifo_data_valid && tx_en && UART_en) begin
               chk("sb_depth", sb.size() > 0, 1);
               if (sb.size() > 0) begin
                 exp_b = sb.pop_front();
                 chk("byte", fifo_data, exp_b);
               end
               tx_fifo_busy = 1'b1;
               ph = 1;
             end
          1: begin
               chk("taken_vld", fifo_data_valid, 1);
               chk("data_stable", fifo_data, exp_b);
               fifo_data_taken = 1'b1;
               ph = 2;
             end
          2: begin
               if (b2b_done < b2b_req) begin
                 chk("b2b_vld", fifo_data_valid, 1);
                 b2b_done++;
               end
               frame = FRAME;
               ph = 3;
             end
          3: if (frame == 0) begin
               tx_fifo_busy = 1'b0;
               ph = 0;
             end else begin
               frame--;
             end
          default: ph = 0;
        endcase
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: run did not finish, failures so far %0d", n_fail);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int g;
    int k;
    RST = 1'b1;
    req_valid = 2'b00;
    req_data = 16'h0000;
    cfg_wr = 1'b0;
    cfg_lcr = 8'h00;
    cfg_tx_en = 1'b0;
    cfg_uart_en = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_word_len", word_len, 2'b11);
    chk("rst_parity_en", parity_en, 0);
    chk("rst_stick", stick_parity_sel, 0);
    chk("rst_break", send_break, 0);
    chk("rst_tx_en", tx_en, 0);
    chk("rst_uart_en", UART_en, 0);
    chk("rst_vld", fifo_data_valid, 0);
    chk("rst_data", fifo_data, 8'h00);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_cfg_busy", cfg_busy, 0);
    chk("rst_cfg_ready", cfg_ready, 0);
    @(negedge CLK);
    RST = 1'b0;

    // Hold 8'h77 while transmitter disabled, then enable: DRAIN must not deadlock
    @(negedge CLK);
    req_valid = 2'b01;
    req_data = 16'h0077;
    #1 chk("g77_ready", req_ready, 2'b01);
    sb.push_back(8'h77);
    @(negedge CLK);
    req_valid = 2'b00;
    #1 chk("h77_vld", fifo_data_valid, 1);
    chk("h77_data", fifo_data, 8'h77);
    @(negedge CLK);
    cfg_wr = 1'b1;
    cfg_lcr = 8'h60;
    cfg_tx_en = 1'b1;
    cfg_uart_en = 1'b1;
    #1 chk("en_cfg_ready", cfg_ready, 1);
    @(negedge CLK);
    cfg_wr = 1'b0;
    #1 chk("en_busy_drain", cfg_busy, 1);
    repeat (3) @(negedge CLK);
    #1 chk("en_tx_low", tx_en, 0);
    chk("en_uart_on", UART_en, 1);
    chk("en_busy_apply", cfg_busy, 1);
    chk("en_h77_kept", fifo_data_valid, 1);
    chk("en_h77_data", fifo_data, 8'h77);
    @(negedge CLK);
    #1 chk("en_tx_high", tx_en, 1);
    chk("en_busy_done", cfg_busy, 0);
    wait_idle("idle_77");

    // Only req1 valid: from pointer 1, then from pointer 0 (wraps back to 0)
    @(negedge CLK);
    req_valid = 2'b10;
    req_data = 16'h5A00;
    #1 chk("g5a_ready", req_ready, 2'b10);
    sb.push_back(8'h5A);
    @(negedge CLK);
    req_valid = 2'b00;
    wait_idle("idle_5a");
    @(negedge CLK);
    req_valid = 2'b10;
    req_data = 16'h5500;
    #1 chk("g55_ready", req_ready, 2'b10);
    sb.push_back(8'h55);
    @(negedge CLK);
    req_valid = 2'b00;
    wait_idle("idle_55");

    // Both requesters valid: A5,3C,A5,3C with back-to-back reloads
    @(negedge CLK);
    req_data = 16'h3CA5;
    req_valid = 2'b11;
    sb.push_back(8'hA5);
    sb.push_back(8'h3C);
    sb.push_back(8'hA5);
    sb.push_back(8'h3C);
    b2b_req = 3;
    g = 0;
    k = 0;
    while (g < 4 && k < 200) begin
      #1;
      if (req_ready != 2'b00) begin
        chk("rr_grant", req_ready, (g % 2 == 0) ? 2'b01 : 2'b10);
        g++;
      end
      @(negedge CLK);
      k++;
    end
    chk("rr_count", g, 4);
    req_valid = 2'b00;
    wait_idle("idle_rr");

    // Update while the transmitter is busy; request in the same cycle as cfg_wr
    @(negedge CLK);
    #1 model_on = 1'b0;
    man_busy = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    cfg_wr = 1'b1;
    cfg_lcr = 8'h46;
    cfg_tx_en = 1'b1;
    cfg_uart_en = 1'b1;
    req_valid = 2'b01;
    req_data = 16'h00A1;
    #1 chk("u_cfg_ready", cfg_ready, 1);
    chk("u_no_grant", req_ready, 2'b00);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      cfg_wr = 1'b0;
      #1 chk("u_drain_busy", cfg_busy, 1);
      chk("u_drain_nogrant", req_ready, 2'b00);
      chk("u_drain_wlen", word_len, 2'b11);
      chk("u_drain_tx", tx_en, 1);
    end
    man_busy = 1'b0;
    @(negedge CLK);
    #1 chk("u_fall_wlen", word_len, 2'b11);
    chk("u_fall_tx", tx_en, 1);
    @(negedge CLK);
    #1 chk("u_dis1_tx", tx_en, 1);
    chk("u_dis1_busy", cfg_busy, 1);
    @(negedge CLK);
    #1 chk("u_dis2_tx", tx_en, 0);
    chk("u_dis2_wlen", word_len, 2'b11);
    chk("u_dis2_nogrant", req_ready, 2'b00);
    @(negedge CLK);
    #1 chk("u_apply_tx", tx_en, 0);
    chk("u_apply_wlen", word_len, 2'b10);
    chk("u_apply_pen", parity_en, 1);
    chk("u_apply_eps", even_parity_sel, 1);
    chk("u_apply_busy", cfg_busy, 1);
    @(negedge CLK);
    #1 chk("u_run_tx", tx_en, 1);
    chk("u_run_busy", cfg_busy, 0);
    chk("u_run_grant", req_ready, 2'b01);
    sb.push_back(8'hA1);
    @(negedge CLK);
    req_valid = 2'b00;
    #1 model_on = 1'b1;
    wait_idle("idle_a1");

    // Reset mid-sequence aborts the update and drops the held byte
    @(negedge CLK);
    #1 model_on = 1'b0;
    @(negedge CLK);
    req_valid = 2'b01;
    req_data = 16'h0099;
    #1 chk("r_grant", req_ready, 2'b01);
    @(negedge CLK);
    req_valid = 2'b00;
    cfg_wr = 1'b1;
    cfg_lcr = 8'h0F;
    @(negedge CLK);
    cfg_wr = 1'b0;
    #1 chk("r_busy", cfg_busy, 1);
    chk("r_held", fifo_data_valid, 1);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    #1 chk("r_busy_clr", cfg_busy, 0);
    chk("r_vld_clr", fifo_data_valid, 0);
    chk("r_data_clr", fifo_data, 8'h00);
    chk("r_tx_clr", tx_en, 0);
    chk("r_uart_clr", UART_en, 0);
    chk("r_wlen_rst", word_len, 2'b11);
    RST = 1'b0;
    @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
